uart_tx_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one UART transmitter (8N1, 434 clk/bit at 100 MHz) between N_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes, issues one tx_start pulse per byte, and holds the grant until the transmitter reports tx_done.
- Sits between the command/response logic and the uart_tx datapath, mirroring the rx_data/rx_done style of the receive side.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit side: frame timing, payload width,
// default requester count and the arbiter state encoding.
// No logic; no latency; no backpressure.
package uart_pkg;
    localparam int CLKS_PER_BIT = 434;
    localparam int DATA_W       = 8;
    localparam int N_REQ_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } arb_state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to act on the pick.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    winner_o,
    output logic             any_valid_o
);
    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        winner_o = ptr_i;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr_i) + k) % N_REQ);
            if (!found && req_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
    end

    assign any_valid_o = |req_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ byte producers (optional watchdog: UART_ARB_TIMEOUT_EN).
// Latency: valid seen at edge k gives tx_start/req_ready in cycle k+1; next grant earliest two cycles after tx_done.
// Backpressure: no grant while tx_busy is high; the grant is held until tx_done (or watchdog expiry).
module uart_tx_arbiter #(
    parameter int N_REQ  = uart_pkg::N_REQ_DEF,
    parameter int DATA_W = uart_pkg::DATA_W
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 8192
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      arb_busy,
    output logic                      err_timeout
);
    import uart_pkg::*;

    localparam int PW = $clog2(N_REQ);

    arb_state_t        state_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [PW-1:0]     grant_id_q;
    logic [DATA_W-1:0] tx_data_q;
    logic [N_REQ-1:0]  req_ready_q;
    logic              tx_start_q;
    logic              arb_busy_q;

    logic [PW-1:0]     winner;
    logic              any_valid;
    logic [PW-1:0]     rr_ptr_d;
    logic [DATA_W-1:0] tx_data_d;
    logic [N_REQ-1:0]  req_ready_d;
    logic              wd_expire;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    assign rr_ptr_d    = (grant_id_q == PW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign tx_data_d   = req_data[winner*DATA_W +: DATA_W];
    assign req_ready_d = {{(N_REQ-1){1'b0}}, 1'b1} << winner;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             err_timeout_q;

    // Count 0 is the first WAIT_DONE cycle, so expiry lands on WAIT_DONE cycle TIMEOUT_CYC.
    assign wd_expire   = (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign err_timeout = err_timeout_q;
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            tx_data_q   <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            arb_busy_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (any_valid && !tx_busy) begin
                        state_q     <= SEND;
                        grant_id_q  <= winner;
                        tx_data_q   <= tx_data_d;
                        tx_start_q  <= 1'b1;
                        req_ready_q <= req_ready_d;
                        arb_busy_q  <= 1'b1;
                    end
                end
                SEND: begin
                    state_q <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end
                WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                    // Pre-register the pulse so it coincides with the expiry cycle.
                    if (!tx_done && wd_cnt_q == CNT_W'(TIMEOUT_CYC - 2)) begin
                        err_timeout_q <= 1'b1;
                    end
`endif
                    if (tx_done || wd_expire) begin
                        state_q    <= IDLE;
                        rr_ptr_q   <= rr_ptr_d;
                        arb_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    arb_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign arb_busy  = arb_busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: directed requests push expected grants,
// a negedge monitor pops and compares on every tx_start.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_busy;
    logic            tx_done;
    logic [1:0]      grant_id;
    logic            arb_busy;
    logic            err_timeout;

    logic model_busy, model_done, force_busy, stray_done, tx_auto;
    int   done_dly;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [1:0] gid;
        logic [7:0] dat;
        int         t;
    } exp_t;
    exp_t exp_q[$];

    assign tx_busy = model_busy | force_busy;
    assign tx_done = model_done | stray_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (100)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_tx(input int g, input logic [7:0] d, input int t);
        exp_t e;
        e.gid = 2'(g);
        e.dat = d;
        e.t   = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input int i, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < budget);
        chk($sformatf("ready_seen_%0d", i), 32'(req_ready[i]), 32'd1);
    endtask

    task automatic take(input int i, input int budget);
        wait_ready(i, budget);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((arb_busy || tx_busy || exp_q.size() != 0) && n < budget);
        chk("wait_idle", 32'(arb_busy | (exp_q.size() != 0)), 32'd0);
        step(1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_tx_start"},    32'(tx_start),    32'd0);
        chk({pfx, "_req_ready"},   32'(req_ready),   32'd0);
        chk({pfx, "_arb_busy"},    32'(arb_busy),    32'd0);
        chk({pfx, "_err_timeout"}, 32'(err_timeout), 32'd0);
        chk({pfx, "_grant_id"},    32'(grant_id),    32'd0);
        chk({pfx, "_tx_data"},     32'(tx_data),     32'd0);
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Transmitter model: busy from tx_start until a tx_done pulse done_dly cycles later.
    initial begin
        model_busy = 1'b0;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && tx_auto) begin
                model_busy = 1'b1;
                repeat (done_dly - 1) @(negedge clk);
                model_done = 1'b1;
                @(negedge clk);
                model_done = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        exp_t       e;
        logic [7:0] cur_data;
        logic [3:0] oh;
        cur_data = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e        = exp_q.pop_front();
                    oh       = 4'b0001 << e.gid;
                    cur_data = e.dat;
                    chk("grant_id",  32'(grant_id),  32'(e.gid));
                    chk("tx_data",   32'(tx_data),   32'(e.dat));
                    chk("req_ready", 32'(req_ready), 32'(oh));
                    chk("arb_busy_send", 32'(arb_busy), 32'd1);
                    if (e.t >= 0) chk("start_cycle", 32'(cyc), 32'(e.t));
                end
            end else begin
                if (req_ready != '0) chk("ready_without_start", 32'(req_ready), 32'd0);
                if (arb_busy) chk("tx_data_hold", 32'(tx_data), 32'(cur_data));
            end
`ifndef UART_ARB_TIMEOUT_EN
            if (err_timeout) chk("err_timeout_tied", 32'(err_timeout), 32'd0);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int send_cyc;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        force_busy = 1'b0;
        stray_done = 1'b0;
        tx_auto    = 1'b1;
        done_dly   = 20;
        step(3);
        @(negedge clk);
        chk_zero("reset");
        step(1);
        rst = 1'b0;

        // All four valid from reset: order 0,1,2,3 with full-length frames.
        done_dly = 4340;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        expect_tx(0, 8'h10, -1);
        expect_tx(1, 8'h21, -1);
        expect_tx(2, 8'h32, -1);
        expect_tx(3, 8'h43, -1);
        req_valid = 4'hF;
        fork
            take(0, 20000);
            take(1, 20000);
            take(2, 20000);
            take(3, 20000);
        join
        wait_idle(5000);

        // Single request, one-cycle latency.
        done_dly = 20;
        req_data[2*DW +: DW] = 8'h42;
        expect_tx(2, 8'h42, cyc + 1);
        req_valid[2] = 1'b1;
        take(2, 200);
        wait_idle(200);

        // Requester 1 continuously valid; 3 arrives during 1's frame and wins next.
        req_data[1*DW +: DW] = 8'h51;
        expect_tx(1, 8'h51, -1);
        expect_tx(3, 8'h73, -1);
        expect_tx(1, 8'h52, -1);
        req_valid[1] = 1'b1;
        wait_ready(1, 200);
        req_data[1*DW +: DW] = 8'h52;
        step(3);
        req_data[3*DW +: DW] = 8'h73;
        req_valid[3] = 1'b1;
        take(3, 200);
        take(1, 200);
        wait_idle(200);

        // Reset in the middle of WAIT_DONE, then a stray tx_done.
        tx_auto = 1'b0;
        req_data[3*DW +: DW] = 8'h6F;
        expect_tx(3, 8'h6F, -1);
        req_valid[3] = 1'b1;
        take(3, 200);
        step(30);
        @(negedge clk);
        chk("wait_busy",    32'(arb_busy), 32'd1);
        chk("wait_data",    32'(tx_data),  32'h6F);
        chk("wait_grant",   32'(grant_id), 32'd3);
        step(1);
        rst = 1'b1;
        step(2);
        @(negedge clk);
        chk_zero("midrst");
        step(1);
        rst        = 1'b0;
        stray_done = 1'b1;
        step(1);
        stray_done = 1'b0;
        step(10);
        @(negedge clk);
        chk_zero("stray_done");
        step(1);
        // rr_ptr must be back at 0: requester 1 beats 2.
        tx_auto = 1'b1;
        req_data[1*DW +: DW] = 8'h1B;
        req_data[2*DW +: DW] = 8'h2B;
        expect_tx(1, 8'h1B, -1);
        expect_tx(2, 8'h2B, -1);
        req_valid = 4'b0110;
        fork
            take(1, 200);
            take(2, 200);
        join
        wait_idle(200);

        // tx_busy blocks the grant; issue follows one cycle after it falls.
        force_busy = 1'b1;
        req_data[0 +: DW] = 8'h0A;
        req_valid[0] = 1'b1;
        step(50);
        @(negedge clk);
        chk("busy_hold_arb",   32'(arb_busy), 32'd0);
        chk("busy_hold_start", 32'(tx_start), 32'd0);
        step(1);
        force_busy = 1'b0;
        expect_tx(0, 8'h0A, cyc + 1);
        take(0, 200);
        wait_idle(200);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: no tx_done, pulse in WAIT_DONE cycle 100, pointer moves past 2.
        tx_auto = 1'b0;
        req_data[2*DW +: DW] = 8'hE2;
        expect_tx(2, 8'hE2, -1);
        req_valid[2] = 1'b1;
        take(2, 200);
        send_cyc = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 150);
        chk("err_cycle", 32'(cyc), 32'(send_cyc + 100));
        @(negedge clk);
        chk("err_width",      32'(err_timeout), 32'd0);
        chk("err_idle_busy",  32'(arb_busy),    32'd0);
        step(1);
        tx_auto = 1'b1;
        req_data[0 +: DW]    = 8'h0C;
        req_data[2*DW +: DW] = 8'h2C;
        expect_tx(0, 8'h0C, -1);
        expect_tx(2, 8'h2C, -1);
        req_valid = 4'b0101;
        fork
            take(0, 200);
            take(2, 200);
        join
        wait_idle(200);
`else
        n        = 0;
        send_cyc = 0;
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
